// File: rtl/rotary_emitter_if.sv
// -----------------------------------------------------------------------------
// rotary_emitter_if
// Command channel into the rotary emitter: a valid/ready handshake carrying
// the direction, the number of detent steps and the per-phase hold period.
//
// Signals
//   cmd_valid   requester has a command
//   cmd_ready   emitter can take a command this cycle
//   cmd_right   1 = clockwise (right), 0 = counter-clockwise (left)
//   cmd_steps   detent steps to emit
//   cmd_period  clock cycles each quadrature phase is held (0 behaves as 1)
//
// Modports
//   master  command source
//   slave   the emitter
// -----------------------------------------------------------------------------
interface rotary_emitter_if #(
   parameter int COUNT_WIDTH  = 8,
   parameter int PERIOD_WIDTH = 16
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_right;
   logic [COUNT_WIDTH-1:0]  cmd_steps;
   logic [PERIOD_WIDTH-1:0] cmd_period;

   modport master (
      output cmd_valid,
      output cmd_right,
      output cmd_steps,
      output cmd_period,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_right,
      input  cmd_steps,
      input  cmd_period,
      output cmd_ready
   );
endinterface

// File: rtl/rotary_emitter.sv
// -----------------------------------------------------------------------------
// rotary_emitter
// Transmit side of the rotary decoder: turns a "N steps left/right" command
// into a clean A:B quadrature waveform. Every detent step is four Gray-coded
// phases that end on 00, and each phase is held for P clock cycles.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-low
//   cmd         command channel (rotary_emitter_if.slave)
//   abort       finish the step in progress, then stop
//   rotary_out  quadrature pair, bit 1 = A, bit 0 = B; 00 whenever idle
//   busy        waveform emission in progress
//   done        one-cycle pulse when a command completes
//   steps_done  steps fully emitted for the current/last command
// -----------------------------------------------------------------------------
module rotary_emitter #(
   parameter int COUNT_WIDTH  = 8,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   rotary_emitter_if.slave        cmd,
   input  logic                   abort,
   output logic [1:0]             rotary_out,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] steps_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FINISH = 2'b10
   } state_t;

   // Clockwise phase order, first phase in the top two bits: 10, 11, 01, 00.
   // The counter-clockwise order is the same walk with A and B swapped.
   localparam logic [7:0] RIGHT_SEQ = 8'b10_11_01_00;

   // Phase index 3 is the 00 rest phase that closes a detent step.
   localparam logic [1:0] LAST_PHASE = 2'd3;

   state_t                  state_reg,      state_next;
   logic                    right_reg,      right_next;
   logic [COUNT_WIDTH-1:0]  steps_reg,      steps_next;
   logic [PERIOD_WIDTH-1:0] reload_reg,     reload_next;
   logic [PERIOD_WIDTH-1:0] phase_cnt_reg,  phase_cnt_next;
   logic [1:0]              phase_idx_reg,  phase_idx_next;
   logic [COUNT_WIDTH-1:0]  steps_done_reg, steps_done_next;
   logic                    abort_reg,      abort_next;
   logic [1:0]              rotary_reg,     rotary_next;

   logic                    ready_int;
   logic                    accept;
   logic [PERIOD_WIDTH-1:0] period_load;
   logic                    phase_expired;
   logic                    step_boundary;
   logic                    last_step;
   logic                    stop_now;

   logic [1:0] right_code [4];
   logic [1:0] left_code  [4];

   // ------------------------------------------------------------------
   // Phase lookup tables
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_phase_table
         assign right_code[gi] = RIGHT_SEQ[7-2*gi -: 2];
         assign left_code[gi]  = {right_code[gi][0], right_code[gi][1]};
      end
   endgenerate

   // ------------------------------------------------------------------
   // Handshake and helper decodes
   // ------------------------------------------------------------------
   // Ready is also gated by reset so nothing can look acceptable while
   // the block is being held in reset.
   assign ready_int     = (state_reg == IDLE) && reset;
   assign cmd.cmd_ready = ready_int;
   assign accept        = cmd.cmd_valid && ready_int;

   // The down-counter is loaded with P-1; a requested period of 0 behaves
   // exactly like a period of 1.
   assign period_load = (cmd.cmd_period == '0) ? '0
                                               : cmd.cmd_period - PERIOD_WIDTH'(1);

   assign phase_expired = (phase_cnt_reg == '0);
   assign step_boundary = phase_expired && (phase_idx_reg == LAST_PHASE);

   // steps_done was already bumped on entry to the rest phase, so equality
   // here means the step that is finishing right now was the last one.
   assign last_step = (steps_done_reg == steps_reg);

   // A pending abort, or one arriving on the boundary edge itself, ends the
   // command once the current step has fully completed.
   assign stop_now = last_step || abort_reg || abort;

   // ------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      right_next      = right_reg;
      steps_next      = steps_reg;
      reload_next     = reload_reg;
      phase_cnt_next  = phase_cnt_reg;
      phase_idx_next  = phase_idx_reg;
      steps_done_next = steps_done_reg;
      abort_next      = abort_reg;
      rotary_next     = 2'b00;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               right_next      = cmd.cmd_right;
               steps_next      = cmd.cmd_steps;
               reload_next     = period_load;
               phase_cnt_next  = period_load;
               phase_idx_next  = 2'd0;
               steps_done_next = '0;
               abort_next      = 1'b0;
               // A zero-step command produces no waveform at all.
               state_next      = (cmd.cmd_steps == '0) ? FINISH : RUN;
            end
         end

         RUN: begin
            if (abort) begin
               abort_next = 1'b1;
            end

            if (!phase_expired) begin
               phase_cnt_next = phase_cnt_reg - PERIOD_WIDTH'(1);
            end else if (!step_boundary) begin
               // Move to the next phase of the current step.
               phase_idx_next = phase_idx_reg + 2'd1;
               phase_cnt_next = reload_reg;
               // A step counts as emitted as soon as the rest phase starts.
               if (phase_idx_reg == LAST_PHASE - 2'd1) begin
                  steps_done_next = steps_done_reg + COUNT_WIDTH'(1);
               end
            end else if (stop_now) begin
               state_next     = FINISH;
               phase_idx_next = 2'd0;
               phase_cnt_next = '0;
            end else begin
               // Start the next step.
               phase_idx_next = 2'd0;
               phase_cnt_next = reload_reg;
            end
         end

         FINISH: begin
            state_next = IDLE;
            abort_next = 1'b0;
         end

         default: begin
            // Unreachable encoding: fall back to a quiet idle.
            state_next     = IDLE;
            abort_next     = 1'b0;
            phase_idx_next = 2'd0;
            phase_cnt_next = '0;
         end
      endcase

      // Output register follows the phase being entered, so the waveform
      // lines up with busy and never glitches.
      if (state_next == RUN) begin
         rotary_next = right_next ? right_code[phase_idx_next]
                                  : left_code[phase_idx_next];
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= IDLE;
         right_reg      <= 1'b0;
         steps_reg      <= '0;
         reload_reg     <= '0;
         phase_cnt_reg  <= '0;
         phase_idx_reg  <= 2'd0;
         steps_done_reg <= '0;
         abort_reg      <= 1'b0;
         rotary_reg     <= 2'b00;
      end else begin
         state_reg      <= state_next;
         right_reg      <= right_next;
         steps_reg      <= steps_next;
         reload_reg     <= reload_next;
         phase_cnt_reg  <= phase_cnt_next;
         phase_idx_reg  <= phase_idx_next;
         steps_done_reg <= steps_done_next;
         abort_reg      <= abort_next;
         rotary_reg     <= rotary_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy       = (state_reg == RUN);
   assign done       = (state_reg == FINISH);
   assign steps_done = steps_done_reg;

   // Forced to 00 outside RUN so an upset encoding can never leave the
   // quadrature lines parked on a non-rest code.
   assign rotary_out = busy ? rotary_reg : 2'b00;

endmodule

// File: tb/tb_rotary_emitter.sv
// -----------------------------------------------------------------------------
// tb_rotary_emitter
// Self-checking bench for rotary_emitter. A cycle-level model derived from
// the step/phase arithmetic predicts every output each cycle; an ideal
// quadrature decoder watches rotary_out; directed cases pin literal values.
// -----------------------------------------------------------------------------
module tb_rotary_emitter;
   localparam int CW = 8;
   localparam int PW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    rotary_out;
   logic          busy;
   logic          done;
   logic [CW-1:0] steps_done;

   rotary_emitter_if #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) cmd_if ();

   rotary_emitter #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd        (cmd_if.slave),
      .abort      (abort),
      .rotary_out (rotary_out),
      .busy       (busy),
      .done       (done),
      .steps_done (steps_done)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Phase p (0..3) of a detent step in the given direction.
   function automatic logic [1:0] seq_code(input bit right, input int p);
      logic [1:0] c;
      case (p)
         0:       c = right ? 2'b10 : 2'b01;
         1:       c = 2'b11;
         2:       c = right ? 2'b01 : 2'b10;
         default: c = 2'b00;
      endcase
      return c;
   endfunction

   // ------------------------------------------------------------------
   // Behavioural model: c = cycles since the accepting edge (1 = first
   // cycle after accept). Emission lasts 4*n*P cycles, done follows.
   // ------------------------------------------------------------------
   bit         m_cmd     = 1'b0;
   int         m_c       = 0;
   int         m_p       = 1;
   int         m_n       = 0;
   bit         m_dir     = 1'b0;
   int         m_sd_hold = 0;
   int         dec_count = 0;
   logic [1:0] prev_rot  = 2'b00;
   logic       prev_reset = 1'b0;

   int         e_busy, e_done, e_ready, e_sd, k, ph, s;
   logic [1:0] e_rot;

   always @(negedge clock) begin
      // expected outputs for this cycle
      if (!m_cmd) begin
         e_busy  = 0;
         e_done  = 0;
         e_rot   = 2'b00;
         e_sd    = m_sd_hold;
         e_ready = int'(reset);
      end else begin
         e_ready = 0;
         if (m_c <= 4 * m_n * m_p) begin
            k      = m_c - 1;
            ph     = (k / m_p) % 4;
            e_busy = 1;
            e_done = 0;
            e_rot  = seq_code(m_dir, ph);
            e_sd   = k / (4 * m_p) + ((ph == 3) ? 1 : 0);
         end else begin
            e_busy = 0;
            e_done = 1;
            e_rot  = 2'b00;
            e_sd   = m_n;
         end
      end

      if (check_en) begin
         check("rotary_out", rotary_out, e_rot);
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("steps_done", steps_done, e_sd);
         check("cmd_ready", cmd_if.cmd_ready, e_ready);

         // ideal decoder: one bit per change, one event per return to 00
         if (prev_reset && rotary_out !== prev_rot) begin
            check("gray_step", $countones(rotary_out ^ prev_rot), 1);
            if (rotary_out == 2'b00) begin
               dec_count++;
               check("dec_dir", (prev_rot == 2'b01) ? 1 : 0, m_dir);
            end
         end
         if (m_cmd && m_c == 4 * m_n * m_p + 1) begin
            check("dec_count", dec_count, m_n);
         end
      end

      // advance model across the coming edge using the inputs now held
      if (!reset) begin
         m_cmd     = 1'b0;
         m_sd_hold = 0;
      end else if (m_cmd) begin
         if (m_c <= 4 * m_n * m_p && abort) begin
            s = (m_c - 1) / (4 * m_p) + 1;
            if (s < m_n) m_n = s;
         end
         if (m_c == 4 * m_n * m_p + 1) begin
            m_cmd     = 1'b0;
            m_sd_hold = m_n;
         end else begin
            m_c++;
         end
      end else if (cmd_if.cmd_valid === 1'b1) begin
         m_cmd     = 1'b1;
         m_c       = 1;
         m_dir     = cmd_if.cmd_right;
         m_n       = int'(cmd_if.cmd_steps);
         m_p       = (cmd_if.cmd_period == '0) ? 1 : int'(cmd_if.cmd_period);
         m_sd_hold = 0;
         dec_count = 0;
      end
      prev_rot   = rotary_out;
      prev_reset = reset;
   end

   // ------------------------------------------------------------------
   // Directed-stimulus helpers
   // ------------------------------------------------------------------
   logic [1:0]    t_rot  [1:40];
   logic          t_busy [1:40];
   logic          t_done [1:40];
   logic [CW-1:0] t_sd   [1:40];
   logic          t_rdy  [1:40];

   // Present a command and return after the accepting edge; the fields are
   // then scrambled to show they no longer matter.
   task automatic issue(input bit dir, input int steps, input int period, output int waited);
      waited = 0;
      @(posedge clock); #1;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_right  = dir;
      cmd_if.cmd_steps  = CW'(steps);
      cmd_if.cmd_period = PW'(period);
      while (cmd_if.cmd_ready !== 1'b1 && waited < 3000) begin
         @(posedge clock); #1;
         waited++;
      end
      if (waited >= 3000) check("accept_timeout", 0, 1);
      @(posedge clock); #1;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_right  = ~dir;
      cmd_if.cmd_steps  = CW'($urandom);
      cmd_if.cmd_period = PW'($urandom_range(0, 7));
   endtask

   // Record outputs for cycles T+1..T+ncyc; abort is high during T+abort_cyc.
   task automatic trace(input int ncyc, input int abort_cyc);
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clock);
         t_rot[i]  = rotary_out;
         t_busy[i] = busy;
         t_done[i] = done;
         t_sd[i]   = steps_done;
         t_rdy[i]  = cmd_if.cmd_ready;
         @(posedge clock); #1;
         abort = (i + 1 == abort_cyc);
      end
      abort = 1'b0;
   endtask

   function automatic logic [15:0] rot_word();
      logic [15:0] w;
      w = '0;
      for (int i = 1; i <= 8; i++) w = {w[13:0], t_rot[i]};
      return w;
   endfunction

   function automatic int first_done(input int ncyc);
      for (int i = 1; i <= ncyc; i++) if (t_done[i] === 1'b1) return i;
      return 0;
   endfunction

   function automatic int busy_count(input int ncyc);
      int n;
      n = 0;
      for (int i = 1; i <= ncyc; i++) if (t_busy[i] === 1'b1) n++;
      return n;
   endfunction

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   int waited;
   int n;
   logic [8:0] bw;

   initial begin
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_right  = 1'b0;
      cmd_if.cmd_steps  = '0;
      cmd_if.cmd_period = '0;
      abort = 1'b0;
      reset = 1'b0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_rotary", rotary_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_steps_done", steps_done, 0);
      check("rst_ready", cmd_if.cmd_ready, 0);
      check_en = 1'b1;

      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("ready_after_reset", cmd_if.cmd_ready, 1);

      // right, 1 step, period 2
      issue(1'b1, 1, 2, waited);
      check("first_accept_wait", waited, 0);
      trace(9, 0);
      check("r1p2_rot", rot_word(), 16'b10_10_11_11_01_01_00_00);
      bw = '0;
      for (int i = 1; i <= 9; i++) bw = {bw[7:0], t_busy[i]};
      check("r1p2_busy", bw, 9'b1_1111_1110);
      check("r1p2_done_at", first_done(9), 9);
      check("r1p2_steps", t_sd[9], 1);

      // left, 2 steps, period 0
      issue(1'b0, 2, 0, waited);
      trace(9, 0);
      check("l2p0_rot", rot_word(), 16'b01_11_10_00_01_11_10_00);
      check("l2p0_sd_t3", t_sd[3], 0);
      check("l2p0_sd_t4", t_sd[4], 1);
      check("l2p0_sd_t8", t_sd[8], 2);
      check("l2p0_done_at", first_done(9), 9);

      // right, 5 steps, period 3, abort pulsed at T+2
      issue(1'b1, 5, 3, waited);
      trace(15, 2);
      check("abort_done_at", first_done(15), 13);
      check("abort_busy_cycles", busy_count(15), 12);
      check("abort_sd", t_sd[13], 1);
      check("abort_rot", t_rot[13], 0);
      check("abort_sd_hold", t_sd[15], 1);

      // zero steps
      issue(1'b1, 0, 3, waited);
      trace(3, 0);
      check("zero_done_at", first_done(3), 1);
      check("zero_busy", busy_count(3), 0);
      check("zero_ready_t1", t_rdy[1], 0);
      check("zero_ready_t2", t_rdy[2], 1);

      // reset mid-run while rotary_out is 11
      issue(1'b1, 3, 2, waited);
      n = 0;
      while (rotary_out !== 2'b11 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("saw_11", rotary_out, 2'b11);
      reset = 1'b0;
      @(posedge clock); #1;
      check("midrst_rot", rotary_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sd", steps_done, 0);
      check("midrst_done", done, 0);
      @(posedge clock); #1;
      check("midrst_done2", done, 0);
      reset = 1'b1;
      issue(1'b0, 1, 1, waited);
      check("postrst_accept_wait", waited, 0);
      trace(5, 0);
      check("postrst_done_at", first_done(5), 5);
      check("postrst_sd", t_sd[5], 1);

      // maximum step count, no wrap
      issue(1'b1, 255, 1, waited);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done !== 1'b1 && n < 1100);
      check("max_done_at", n, 4 * 255 + 1);
      check("max_sd", steps_done, 255);

      // randomized traffic with aborts, field churn and rare resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clock); #1;
         cmd_if.cmd_valid  = ($urandom_range(0, 2) == 0);
         cmd_if.cmd_right  = $urandom_range(0, 1);
         cmd_if.cmd_steps  = CW'($urandom_range(0, 6));
         cmd_if.cmd_period = PW'($urandom_range(0, 4));
         abort = ($urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 399) != 0);
      end
      @(posedge clock); #1;
      cmd_if.cmd_valid = 1'b0;
      abort = 1'b0;
      reset = 1'b1;
      repeat (150) @(posedge clock);
      @(negedge clock);
      check("drain_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/rotary_emitter.md
ROTARY_EMITTER -- requirements
Module: rotary_emitter

Interface
REQ-001 Parameter COUNT_WIDTH, default 8: width of the step-count fields.
REQ-002 Parameter PERIOD_WIDTH, default 16: width of the phase-period field.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_right  input  1  direction: 1 = right (clockwise), 0 = left.
REQ-008 cmd_steps  input  COUNT_WIDTH  number of detent steps to emit.
REQ-009 cmd_period  input  PERIOD_WIDTH  clock cycles each quadrature phase is held; 0 treated as 1.
REQ-010 abort  input  1  stop after the step in progress completes.
REQ-011 rotary_out  output  2  quadrature pair, bit 1 = A, bit 0 = B.
REQ-012 busy  output  1  waveform emission in progress.
REQ-013 done  output  1  one-cycle pulse on command completion.
REQ-014 steps_done  output  COUNT_WIDTH  steps fully emitted for the current/last command.

Function
REQ-015 Block SHALL generate a debounce-free A:B quadrature waveform, the transmit side of the team's rotary decoder, each detent step being four Gray-coded phases returning to 00.
REQ-016 Right step sequence SHALL be 10, 11, 01, 00; left step sequence SHALL be 01, 11, 10, 00.
REQ-017 rotary_out SHALL change by exactly one bit per transition and SHALL be 00 whenever not busy.
REQ-018 FSM states SHALL be IDLE, RUN, FINISH; every other encoding SHALL return to IDLE with rotary_out 00.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted in cycle T when cmd_valid and cmd_ready are both 1.
REQ-020 On accept, cmd_right, cmd_steps and cmd_period SHALL be latched; later changes on those inputs SHALL have no effect until the next accept.
REQ-021 On accept, steps_done SHALL clear to 0.
REQ-022 If latched steps > 0, FSM SHALL enter RUN at T+1 with busy 1 and rotary_out equal to the first phase of the step sequence.
REQ-023 Each phase SHALL be held exactly P cycles (P = latched period, or 1 if 0) using a down-counter loaded with P-1; phase advances when counter reaches 0.
REQ-024 steps_done SHALL increment in the cycle rotary_out enters the final 00 phase of a step.
REQ-025 After the final 00 phase of the last step has been held P cycles, FSM SHALL enter FINISH: busy 0, done 1 for one cycle, cmd_ready 0; next cycle IDLE.
REQ-026 Total busy cycles per command SHALL be exactly 4 x steps x P; done SHALL be at T+1+4 x steps x P.
REQ-027 If latched steps = 0, FSM SHALL go to FINISH at T+1 with no waveform, done at T+1.
REQ-028 abort sampled 1 in RUN SHALL be remembered; emission SHALL stop at the next step boundary (after the 00 phase is held P cycles), then FINISH as in REQ-025.
REQ-029 abort SHALL never truncate a phase or a step; abort in IDLE or FINISH SHALL be ignored, and abort does not block acceptance.
REQ-030 steps_done SHALL hold its final value after completion until the next accept.
REQ-031 Counter arithmetic SHALL be unsigned; steps_done SHALL never exceed latched steps; maximum steps (all ones) SHALL complete without wrap.

Reset
REQ-032 While reset is 0 at a rising edge: FSM to IDLE, rotary_out 00, busy 0, done 0, steps_done 0, abort flag clear, phase counter 0; cmd_ready 0 while reset is 0.
REQ-033 Reset mid-RUN SHALL force rotary_out to 00 on the next edge (Gray violation accepted) and discard the command.
REQ-034 First command SHALL be acceptable the cycle after reset returns to 1.

Verification
REQ-035 Right, steps=1, period=2, accepted at T -> rotary_out 10,10,11,11,01,01,00,00 over T+1..T+8; busy T+1..T+8; done at T+9; steps_done 1.
REQ-036 Left, steps=2, period=0 -> rotary_out 01,11,10,00,01,11,10,00 over T+1..T+8; steps_done 1 at T+4, 2 at T+8; done at T+9.
REQ-037 Right, steps=5, period=3, abort pulsed at T+2 -> one full step (12 cycles) emitted, done at T+13, steps_done 1, rotary_out 00.
REQ-038 steps=0 -> no rotary_out change, busy stays 0, done at T+1, cmd_ready 1 at T+2.
REQ-039 reset driven 0 mid-RUN with rotary_out 11 -> next edge rotary_out 00, busy 0, steps_done 0, no done pulse; new command accepted after reset returns to 1.
REQ-040 Loopback through the team's rotary decoder, random directions/steps, period >= 2 -> decoder event count equals steps_done and direction matches cmd_right for every step.
